// File: rtl/adc_scan_sequencer_generic_if.sv
// adc_scan_sequencer_generic_if: request/result/serial bundle between the scan sequencer and its host/ADC
interface adc_scan_sequencer_generic_if #(
  parameter int Channel_Count = 8,
  parameter int Data_Width = 12
);
  localparam int Addr_Width = $clog2(Channel_Count);
  logic clk_en, single_req, scan_req, continuous_en, stop_req;
  logic [Addr_Width-1:0] channel_addr;
  logic [Channel_Count-1:0] channel_mask;
  logic req_ack, busy, scan_done, sample_strobe;
  logic [Addr_Width-1:0] sample_channel;
  logic [Data_Width-1:0] sample_data;
  logic [Channel_Count*Data_Width-1:0] channels_out;
  logic [Channel_Count-1:0] channel_valid;
  logic sclk, cs_n, copi, copi_en, cipo;
  modport slave (
    input clk_en, single_req, scan_req, continuous_en, stop_req, channel_addr, channel_mask, cipo,
    output req_ack, busy, scan_done, sample_strobe, sample_channel, sample_data, channels_out,
    channel_valid, sclk, cs_n, copi, copi_en
  );
  modport master (
    output clk_en, single_req, scan_req, continuous_en, stop_req, channel_addr, channel_mask, cipo,
    input req_ack, busy, scan_done, sample_strobe, sample_channel, sample_data, channels_out,
    channel_valid, sclk, cs_n, copi, copi_en
  );
endinterface

// File: rtl/adc_scan_sequencer_generic.sv
// adc_scan_sequencer_generic: serial ADC scan sequencer with pipelined addressing and result bank
module adc_scan_sequencer_generic #(
  parameter int Channel_Count = 8,
  parameter int Data_Width = 12,
  parameter int Frame_Width = 16,
  parameter int Addr_Lsb = 11,
  parameter int Half_Period = 10,
  parameter int Scan_Gap = 4
) (
  input logic clk,
  input logic async_rst,
  adc_scan_sequencer_generic_if.slave bus
);
  localparam int AW = $clog2(Channel_Count);
  localparam int BW = $clog2(Frame_Width + 1);
  typedef enum logic [2:0] {S_IDLE, S_EMPTY, S_SETUP, S_SHIFT, S_STORE, S_HOLD, S_GAP} state_t;
  state_t r_state;
  logic [15:0] r_tick;
  logic [BW-1:0] r_bit;
  logic [Frame_Width-1:0] r_tx, r_rx;
  logic [Channel_Count-1:0] r_todo, r_valid;
  logic [Channel_Count-1:0][Data_Width-1:0] r_bank;
  logic [AW-1:0] r_cur, r_sch;
  logic [Data_Width-1:0] r_sdata;
  logic r_drop, r_cont, r_stop, r_busy, r_ack, r_done, r_strobe, r_sclk, r_cs_n, r_copi, r_copi_en;
  logic [Channel_Count-1:0] w_init_mask;
  logic [AW-1:0] w_first, w_second;
  logic [Frame_Width-1:0] w_word_first, w_word_second;
  logic w_hp_end, w_gap_end;
  function automatic logic [AW-1:0] lowest(input logic [Channel_Count-1:0] m);
    lowest = '0;
    for (int k = Channel_Count - 1; k >= 0; k--) if (m[k]) lowest = AW'(k);
  endfunction
  // r_todo holds list entries not yet assigned to a frame; the frame in flight returns r_cur
  assign w_init_mask = (r_state == S_IDLE) ? (bus.scan_req ? bus.channel_mask : Channel_Count'(1) << bus.channel_addr) : bus.channel_mask;
  assign w_first = lowest(r_todo);
  assign w_second = lowest(r_todo & ~(Channel_Count'(1) << w_first));
  assign w_word_first = Frame_Width'(w_first) << Addr_Lsb;
  assign w_word_second = Frame_Width'(w_second) << Addr_Lsb;
  assign w_hp_end = r_tick == 16'(Half_Period - 1);
  assign w_gap_end = r_tick == 16'(Scan_Gap - 1);
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) begin
      r_state <= S_IDLE;
      r_tick <= '0;
      r_bit <= '0;
      r_tx <= '0;
      r_rx <= '0;
      r_todo <= '0;
      r_valid <= '0;
      r_bank <= '0;
      r_cur <= '0;
      r_sch <= '0;
      r_sdata <= '0;
      {r_drop, r_cont, r_stop, r_busy, r_ack, r_done, r_strobe, r_copi, r_copi_en} <= '0;
      r_sclk <= 1'b1;
      r_cs_n <= 1'b1;
    end else begin
      r_ack <= 1'b0;
      r_done <= 1'b0;
      r_strobe <= 1'b0;
      if (bus.clk_en) begin
        if (r_busy && bus.stop_req) r_stop <= 1'b1;
        case (r_state)
          S_IDLE: if (bus.scan_req || bus.single_req) begin
            r_ack <= 1'b1;
            r_busy <= 1'b1;
            r_cont <= bus.scan_req && bus.continuous_en;
            r_stop <= 1'b0;
            r_tick <= '0;
            r_state <= (w_init_mask == '0) ? S_EMPTY : S_SETUP;
            r_cs_n <= w_init_mask == '0;
            r_copi_en <= w_init_mask != '0;
            r_todo <= w_init_mask & ~Channel_Count'(1);
            r_cur <= '0;
            r_drop <= ~w_init_mask[0];
          end
          S_EMPTY: begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_state <= S_IDLE;
          end
          S_SETUP: begin
            r_tick <= w_hp_end ? '0 : r_tick + 16'd1;
            if (w_hp_end) begin
              r_state <= S_SHIFT;
              r_sclk <= 1'b0;
              r_copi <= w_word_first[Frame_Width-1];
              r_tx <= w_word_first << 1;
              r_bit <= '0;
            end
          end
          S_SHIFT: begin
            r_tick <= w_hp_end ? '0 : r_tick + 16'd1;
            if (w_hp_end) begin
              if (!r_sclk) begin
                r_sclk <= 1'b1;
                r_rx <= {r_rx[Frame_Width-2:0], bus.cipo};
                r_bit <= r_bit + 1'b1;
              end else if (r_bit == BW'(Frame_Width)) r_state <= S_STORE;
              else begin
                r_sclk <= 1'b0;
                r_copi <= r_tx[Frame_Width-1];
                r_tx <= r_tx << 1;
              end
            end
          end
          S_STORE: begin
            if (!r_drop) begin
              r_bank[r_cur] <= r_rx[Data_Width-1:0];
              r_valid[r_cur] <= 1'b1;
              r_strobe <= 1'b1;
              r_sch <= r_cur;
              r_sdata <= r_rx[Data_Width-1:0];
            end
            r_done <= r_todo == '0;
            r_tick <= '0;
            if (r_todo == '0 || r_stop || bus.stop_req) begin
              r_state <= S_HOLD;
              r_copi <= 1'b0;
            end else begin
              r_state <= S_SHIFT;
              r_cur <= w_first;
              r_todo <= r_todo & ~(Channel_Count'(1) << w_first);
              r_drop <= 1'b0;
              r_sclk <= 1'b0;
              r_copi <= w_word_second[Frame_Width-1];
              r_tx <= w_word_second << 1;
              r_bit <= '0;
            end
          end
          S_HOLD: begin
            r_tick <= w_hp_end ? '0 : r_tick + 16'd1;
            if (w_hp_end) begin
              r_cs_n <= 1'b1;
              r_copi_en <= 1'b0;
              r_state <= (r_cont && !r_stop && !bus.stop_req) ? S_GAP : S_IDLE;
              r_busy <= r_cont && !r_stop && !bus.stop_req;
            end
          end
          S_GAP: begin
            r_tick <= w_gap_end ? '0 : r_tick + 16'd1;
            if (w_gap_end) begin
              if (w_init_mask == '0 || r_stop || bus.stop_req) begin
                r_state <= S_IDLE;
                r_busy <= 1'b0;
              end else begin
                r_state <= S_SETUP;
                r_cs_n <= 1'b0;
                r_copi_en <= 1'b1;
                r_todo <= w_init_mask & ~Channel_Count'(1);
                r_cur <= '0;
                r_drop <= ~w_init_mask[0];
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  assign bus.req_ack = r_ack;
  assign bus.busy = r_busy;
  assign bus.scan_done = r_done;
  assign bus.sample_strobe = r_strobe;
  assign bus.sample_channel = r_sch;
  assign bus.sample_data = r_sdata;
  assign bus.channels_out = r_bank;
  assign bus.channel_valid = r_valid;
  assign bus.sclk = r_sclk;
  assign bus.cs_n = r_cs_n;
  assign bus.copi = r_copi;
  assign bus.copi_en = r_copi_en;
endmodule
